morse_encoder_param: RTL and testbench
======================================

# morse_encoder_param

Parametrised Morse-code transmitter for the lab display path. It accepts a letter code A–Z on a one-cycle Start request and serialises the ITU Morse pattern on DotDashOut at a programmable symbol-unit rate. It reports progress with Busy, Done and Error, and can optionally repeat the letter with a fixed inter-letter gap. It replaces the fixed eight-letter, fixed-rate encoder and drives an LED directly.

## Interface
- CLK_PER_UNIT, default 250: ClockIn cycles per Morse unit; legal range 1..65535.
- GAP_UNITS, default 3: low units inserted between repetitions in Repeat mode; legal range 1..15.
- ClockIn  input  1  single clock; all state changes on its rising edge.
- Reset  input  1  synchronous, active-high reset.
- Start  input  1  request to send; sampled only in IDLE.
- Letter  input  5  letter code, 0=A … 25=Z; 26–31 invalid; sampled with Start.
- Repeat  input  1  when high, the latched letter is resent continuously.
- DotDashOut  output  1  serial Morse stream; 1 = tone/LED on.
- Busy  output  1  high while in SEND or GAP.
- Done  output  1  one-cycle pulse when a transmission ends normally.
- Error  output  1  one-cycle pulse when Start is seen with an invalid Letter.

## Operation
- Encoding:
  - Dot = "1", dash = "111", intra-letter space = "0".
  - Patterns are stored MSB-first in a 16-bit ROM word with a 4-bit length field. Maximum length is 13 (J, Q, Y).
  - Examples: A=10111/5, E=1/1, T=111/3, S=10101/5, O=11101110111/11.
  - No trailing zeros are stored.
- State machine states: IDLE, SEND, GAP.
- IDLE:
  - DotDashOut=0, Busy=0.
  - Start=1 with a valid Letter: latch Letter, load the pattern shift register and length counter, set the unit-tick counter to CLK_PER_UNIT-1, go to SEND.
  - Start=1 with an invalid Letter: Error=1 for one cycle, stay in IDLE.
- SEND:
  - DotDashOut = pattern MSB.
  - The tick counter decrements each cycle. At 0 it reloads, the pattern shifts left by one, and the length counter decrements.
  - When the last unit's tick reaches 0:
    - Repeat=1: go to GAP with the gap counter set to GAP_UNITS.
    - Otherwise: go to IDLE and pulse Done.
- GAP:
  - DotDashOut=0 for GAP_UNITS units.
  - At gap end, Repeat=1: reload the pattern from the latched letter and go to SEND.
  - At gap end, Repeat=0: go to IDLE and pulse Done.
- Start while Busy is ignored, and the Letter input is not re-sampled.
- Repeat is evaluated only at the end of SEND and at the end of GAP. Changes mid-letter have no effect until then.
- Counter widths:
  - Tick counter: $clog2(CLK_PER_UNIT) bits, minimum 1.
  - Length counter: 4 bits.
  - Gap counter: 4 bits.
  - All counters are unsigned decrementers with no wrap. Each reloads only at its defined terminal condition.
- Reset:
  - Reset=1 forces IDLE and clears all counters and the shift register.
  - DotDashOut, Busy, Done and Error are all 0.
  - Reset has priority over Start and over every other transition.

## Timing
- Start is sampled at edge k in IDLE. Busy=1 and DotDashOut = first unit value from cycle k+1.
- Each unit holds for exactly CLK_PER_UNIT cycles. A letter of length L occupies cycles k+1 .. k+L·CLK_PER_UNIT.
- At cycle k+L·CLK_PER_UNIT+1 (non-repeat):
  - Busy=0, DotDashOut=0, Done=1 for that cycle only.
  - A new Start may be accepted at the edge that ends that cycle.
- In Repeat mode, period = (L+GAP_UNITS)·CLK_PER_UNIT cycles and Busy stays high throughout.
- Error is asserted in cycle k+1 for one cycle; Busy stays 0.
- With CLK_PER_UNIT=1 the output changes every cycle, with no extra bubble between units or states.
- Reset asserted mid-transmission at edge r: from cycle r+1 all outputs are 0 and no Done is generated.

## Test plan
- CLK_PER_UNIT=4. Reset, then Start with Letter=0 (A) -> DotDashOut is:
  - 1 for 4 cycles, 0 for 4, 1 for 12;
  - Busy high for 20 cycles;
  - Done for one cycle immediately after;
  - output 0 thereafter.
- CLK_PER_UNIT=1, Letter=4 (E) -> DotDashOut=1 for exactly one cycle. Then Busy=0 and Done=1 in the next cycle. A back-to-back Start with Letter=19 (T) on the Done cycle -> 111 follows with no gap.
- CLK_PER_UNIT=2, GAP_UNITS=3, Repeat=1, Letter=19 (T) -> repeating 111111 000000 with Busy constantly high. Drop Repeat during a SEND -> that letter completes, no gap follows, Done pulses once.
- Start with Letter=27 -> Error pulse of 1 cycle, Busy=0, DotDashOut=0. Start with Letter=14 (O) while busy sending S -> ignored; S completes unchanged.
- CLK_PER_UNIT=4, Letter=14 (O), Reset high at cycle 10 of transmission -> cycle 11 all outputs 0, no Done. A subsequent Start with A -> the full A pattern is sent correctly.

Source files
------------

// File: rtl/morse_encoder_param.sv
// Morse-code transmitter: serialises the ITU pattern of letter A..Z at a
// programmable unit rate, with optional continuous repeat separated by a fixed gap.
module morse_encoder_param #(
    parameter int unsigned CLK_PER_UNIT = 250,
    parameter int unsigned GAP_UNITS    = 3
) (
    input  logic       ClockIn,
    input  logic       Reset,
    input  logic       Start,
    input  logic [4:0] Letter,
    input  logic       Repeat,
    output logic       DotDashOut,
    output logic       Busy,
    output logic       Done,
    output logic       Error
);

    localparam int unsigned TW = (CLK_PER_UNIT > 1) ? $clog2(CLK_PER_UNIT) : 1;
    localparam logic [TW-1:0] TICK_RELOAD = TW'(CLK_PER_UNIT - 1);
    localparam logic [3:0]    GAP_RELOAD  = 4'(GAP_UNITS);
    localparam logic [4:0]    LAST_CODE   = 5'd25;

    typedef enum logic [1:0] {IDLE = 2'd0, SEND = 2'd1, GAP = 2'd2} state_t;

    // Returns {length, pattern left-aligned so the first unit sits in bit 15}.
    function automatic logic [19:0] rom_lookup(input logic [4:0] code);
        logic [19:0] e;
        e = 20'd0;
        case (code)
            5'd0:  e = {4'd5,  16'b10111};
            5'd1:  e = {4'd9,  16'b111010101};
            5'd2:  e = {4'd11, 16'b11101011101};
            5'd3:  e = {4'd7,  16'b1110101};
            5'd4:  e = {4'd1,  16'b1};
            5'd5:  e = {4'd9,  16'b101011101};
            5'd6:  e = {4'd9,  16'b111011101};
            5'd7:  e = {4'd7,  16'b1010101};
            5'd8:  e = {4'd3,  16'b101};
            5'd9:  e = {4'd13, 16'b1011101110111};
            5'd10: e = {4'd9,  16'b111010111};
            5'd11: e = {4'd9,  16'b101110101};
            5'd12: e = {4'd7,  16'b1110111};
            5'd13: e = {4'd5,  16'b11101};
            5'd14: e = {4'd11, 16'b11101110111};
            5'd15: e = {4'd11, 16'b10111011101};
            5'd16: e = {4'd13, 16'b1110111010111};
            5'd17: e = {4'd7,  16'b1011101};
            5'd18: e = {4'd5,  16'b10101};
            5'd19: e = {4'd3,  16'b111};
            5'd20: e = {4'd7,  16'b1010111};
            5'd21: e = {4'd9,  16'b101010111};
            5'd22: e = {4'd9,  16'b101110111};
            5'd23: e = {4'd11, 16'b11101010111};
            5'd24: e = {4'd13, 16'b1110101110111};
            5'd25: e = {4'd11, 16'b11101110101};
            default: e = 20'd0;
        endcase
        return {e[19:16], e[15:0] << (5'd16 - {1'b0, e[19:16]})};
    endfunction

    state_t        state, state_n;
    logic [TW-1:0] tick, tick_n;
    logic [3:0]    len_cnt, len_n;
    logic [3:0]    gap_cnt, gap_n;
    logic [15:0]   shreg, shreg_n;
    logic [4:0]    letter_q, letter_n;
    logic          dd_n, busy_n, done_n, err_n;
    logic [19:0]   rom_in, rom_q;

    // Next-state, datapath and next-output logic
    always_comb begin
        state_n  = state;
        tick_n   = tick;
        len_n    = len_cnt;
        gap_n    = gap_cnt;
        shreg_n  = shreg;
        letter_n = letter_q;
        dd_n     = 1'b0;
        busy_n   = 1'b0;
        done_n   = 1'b0;
        err_n    = 1'b0;
        rom_in   = rom_lookup(Letter);
        rom_q    = rom_lookup(letter_q);

        case (state)
            IDLE: begin
                if (Start) begin
                    if (Letter <= LAST_CODE) begin
                        letter_n = Letter;
                        shreg_n  = rom_in[15:0];
                        len_n    = rom_in[19:16];
                        tick_n   = TICK_RELOAD;
                        state_n  = SEND;
                        dd_n     = rom_in[15];
                        busy_n   = 1'b1;
                    end else begin
                        err_n = 1'b1;
                    end
                end
            end
            SEND: begin
                busy_n = 1'b1;
                dd_n   = shreg[15];
                if (tick != '0) begin
                    tick_n = tick - 1'b1;
                end else begin
                    tick_n  = TICK_RELOAD;
                    shreg_n = {shreg[14:0], 1'b0};
                    len_n   = len_cnt - 1'b1;
                    dd_n    = shreg[14];
                    if (len_cnt == 4'd1) begin
                        dd_n = 1'b0;
                        if (Repeat) begin
                            state_n = GAP;
                            gap_n   = GAP_RELOAD;
                        end else begin
                            state_n = IDLE;
                            busy_n  = 1'b0;
                            done_n  = 1'b1;
                        end
                    end
                end
            end
            GAP: begin
                busy_n = 1'b1;
                if (tick != '0) begin
                    tick_n = tick - 1'b1;
                end else begin
                    tick_n = TICK_RELOAD;
                    gap_n  = gap_cnt - 1'b1;
                    if (gap_cnt == 4'd1) begin
                        if (Repeat) begin
                            state_n = SEND;
                            shreg_n = rom_q[15:0];
                            len_n   = rom_q[19:16];
                            dd_n    = rom_q[15];
                        end else begin
                            state_n = IDLE;
                            busy_n  = 1'b0;
                            done_n  = 1'b1;
                        end
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // State, datapath and registered outputs
    always_ff @(posedge ClockIn) begin
        if (Reset) begin
            state      <= IDLE;
            tick       <= '0;
            len_cnt    <= '0;
            gap_cnt    <= '0;
            shreg      <= '0;
            letter_q   <= '0;
            DotDashOut <= 1'b0;
            Busy       <= 1'b0;
            Done       <= 1'b0;
            Error      <= 1'b0;
        end else begin
            state      <= state_n;
            tick       <= tick_n;
            len_cnt    <= len_n;
            gap_cnt    <= gap_n;
            shreg      <= shreg_n;
            letter_q   <= letter_n;
            DotDashOut <= dd_n;
            Busy       <= busy_n;
            Done       <= done_n;
            Error      <= err_n;
        end
    end

endmodule

// File: tb/tb_morse_encoder_param.sv
// Bench for morse_encoder_param: three instances at unit rates 4, 1 and 2,
// checked every cycle against a queue-based model built from dot/dash strings.
module tb_morse_encoder_param;

    localparam int GAPU = 3;

    logic       clk = 1'b0;
    logic [2:0] rst, start, rep;
    logic [4:0] ltr [3];
    logic [2:0] dd, busy, done, err;

    always #5 clk = ~clk;

    morse_encoder_param #(.CLK_PER_UNIT(4), .GAP_UNITS(GAPU)) u_c4 (
        .ClockIn(clk), .Reset(rst[0]), .Start(start[0]), .Letter(ltr[0]), .Repeat(rep[0]),
        .DotDashOut(dd[0]), .Busy(busy[0]), .Done(done[0]), .Error(err[0]));
    morse_encoder_param #(.CLK_PER_UNIT(1), .GAP_UNITS(GAPU)) u_c1 (
        .ClockIn(clk), .Reset(rst[1]), .Start(start[1]), .Letter(ltr[1]), .Repeat(rep[1]),
        .DotDashOut(dd[1]), .Busy(busy[1]), .Done(done[1]), .Error(err[1]));
    morse_encoder_param #(.CLK_PER_UNIT(2), .GAP_UNITS(GAPU)) u_c2 (
        .ClockIn(clk), .Reset(rst[2]), .Start(start[2]), .Letter(ltr[2]), .Repeat(rep[2]),
        .DotDashOut(dd[2]), .Busy(busy[2]), .Done(done[2]), .Error(err[2]));

    string code_of [26] = '{".-", "-...", "-.-.", "-..", ".", "..-.", "--.", "....", "..",
                            ".---", "-.-", ".-..", "--", "-.", "---", ".--.", "--.-", ".-.",
                            "...", "-", "..-", "...-", ".--", "-..-", "-.--", "--.."};

    // o = {dd, busy, done, err}; tag 1 = last SEND cycle, tag 2 = last GAP cycle
    typedef struct {
        logic [3:0] o;
        int         tag;
        int         letter;
    } exp_t;

    exp_t eq [3][$];
    int n_chk = 0;
    int n_pass = 0;

    function automatic int cpu_of(int i);
        return (i == 0) ? 4 : ((i == 1) ? 1 : 2);
    endfunction

    task automatic check(string nm, logic [31:0] act, logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    endtask

    task automatic push_letter(int i, int l);
        bit    u [$];
        string s;
        s = code_of[l];
        for (int j = 0; j < s.len(); j++) begin
            if (j > 0) u.push_back(1'b0);
            if (s.getc(j) == "-") begin
                u.push_back(1'b1); u.push_back(1'b1); u.push_back(1'b1);
            end else begin
                u.push_back(1'b1);
            end
        end
        for (int j = 0; j < u.size(); j++) begin
            for (int c = 0; c < cpu_of(i); c++) begin
                exp_t e;
                e.o      = {u[j], 1'b1, 1'b0, 1'b0};
                e.tag    = (j == u.size() - 1 && c == cpu_of(i) - 1) ? 1 : 0;
                e.letter = l;
                eq[i].push_back(e);
            end
        end
    endtask

    task automatic push_gap(int i, int l);
        for (int c = 0; c < GAPU * cpu_of(i); c++) begin
            exp_t e;
            e.o      = 4'b0100;
            e.tag    = (c == GAPU * cpu_of(i) - 1) ? 2 : 0;
            e.letter = l;
            eq[i].push_back(e);
        end
    endtask

    task automatic push_ctl(int i, logic [3:0] o);
        exp_t e;
        e.o = o; e.tag = 0; e.letter = 0;
        eq[i].push_back(e);
    endtask

    // Compare one cycle, then extend the expectation using inputs the next edge samples
    task automatic step(int i);
        exp_t e;
        if (eq[i].size() > 0) e = eq[i].pop_front();
        else begin e.o = 4'b0000; e.tag = 0; e.letter = 0; end
        check($sformatf("model_out%0d", i), 32'({dd[i], busy[i], done[i], err[i]}), 32'(e.o));
        if (rst[i]) begin
            eq[i].delete();
        end else if (e.tag == 1) begin
            if (rep[i]) push_gap(i, e.letter); else push_ctl(i, 4'b0010);
        end else if (e.tag == 2) begin
            if (rep[i]) push_letter(i, e.letter); else push_ctl(i, 4'b0010);
        end else if (!e.o[2] && start[i]) begin
            if (ltr[i] <= 5'd25) push_letter(i, int'(ltr[i])); else push_ctl(i, 4'b0001);
        end
    endtask

    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) step(i);
    end

    task automatic cyc(int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse(int i, logic [4:0] l);
        start[i] = 1'b1;
        ltr[i]   = l;
        cyc(1);
        start[i] = 1'b0;
    endtask

    typedef struct {
        logic [4:0]  l;
        int          len;
        logic [15:0] bits;
        bit          is_err;
    } vec_t;

    initial begin
        vec_t        tv [8];
        logic [15:0] got;
        logic [19:0] w20;
        logic [23:0] w24;
        logic [2:0]  w3;
        int          bc, dc;

        tv[0] = '{5'd0,  5,  16'b10111,         1'b0};
        tv[1] = '{5'd4,  1,  16'b1,             1'b0};
        tv[2] = '{5'd19, 3,  16'b111,           1'b0};
        tv[3] = '{5'd18, 5,  16'b10101,         1'b0};
        tv[4] = '{5'd14, 11, 16'b11101110111,   1'b0};
        tv[5] = '{5'd9,  13, 16'b1011101110111, 1'b0};
        tv[6] = '{5'd25, 11, 16'b11101110101,   1'b0};
        tv[7] = '{5'd26, 0,  16'b0,             1'b1};

        rst = 3'b111; start = 3'b000; rep = 3'b000;
        for (int i = 0; i < 3; i++) ltr[i] = 5'd0;
        cyc(3);
        rst = 3'b000;
        cyc(1);
        check("reset_idle", 32'({dd, busy, done, err}), 32'd0);

        // Table of letters on the one-cycle-per-unit instance
        for (int t = 0; t < 8; t++) begin
            pulse(1, tv[t].l);
            if (tv[t].is_err) begin
                check("tbl_err", 32'({err[1], busy[1], dd[1]}), 32'b100);
                cyc(1);
                check("tbl_err_clear", 32'(err[1]), 32'd0);
            end else begin
                got = '0; bc = 0;
                for (int j = 0; j < tv[t].len; j++) begin
                    got = {got[14:0], dd[1]};
                    bc += int'(busy[1]);
                    cyc(1);
                end
                check($sformatf("tbl_bits_%0d", tv[t].l), 32'(got), 32'(tv[t].bits));
                check("tbl_busy", bc, tv[t].len);
                check("tbl_done", 32'({busy[1], done[1]}), 32'b01);
            end
            cyc(2);
        end

        // A at 4 clocks per unit
        pulse(0, 5'd0);
        w20 = '0; bc = 0;
        for (int j = 0; j < 20; j++) begin
            w20 = {w20[18:0], dd[0]}; bc += int'(busy[0]); cyc(1);
        end
        check("a_bits", 32'(w20), 32'h000F0FFF);
        check("a_busy", bc, 20);
        check("a_done", 32'({dd[0], busy[0], done[0]}), 32'b001);
        cyc(1);
        check("a_after", 32'({dd[0], busy[0], done[0]}), 32'b000);

        // E then T back-to-back on the Done cycle
        pulse(1, 5'd4);
        check("e_on", 32'({dd[1], busy[1]}), 32'b11);
        cyc(1);
        check("e_done", 32'({dd[1], busy[1], done[1]}), 32'b001);
        start[1] = 1'b1; ltr[1] = 5'd19;
        cyc(1);
        start[1] = 1'b0;
        w3 = '0; bc = 0;
        for (int j = 0; j < 3; j++) begin
            w3 = {w3[1:0], dd[1]}; bc += int'(busy[1]); cyc(1);
        end
        check("t_bits", 32'(w3), 32'b111);
        check("t_busy", bc, 3);
        check("t_done", 32'(done[1]), 32'd1);
        cyc(2);

        // Repeated T, then Repeat dropped mid-letter
        rep[2] = 1'b1;
        pulse(2, 5'd19);
        w24 = '0; bc = 0;
        for (int j = 0; j < 24; j++) begin
            w24 = {w24[22:0], dd[2]}; bc += int'(busy[2]); cyc(1);
        end
        check("rep_bits", 32'(w24), 32'h00FC0FC0);
        check("rep_busy", bc, 24);
        cyc(1);
        rep[2] = 1'b0;
        dc = 0;
        for (int j = 0; j < 20; j++) begin
            dc += int'(done[2]); cyc(1);
        end
        check("rep_drop_done", dc, 1);
        check("rep_idle", 32'({dd[2], busy[2]}), 32'd0);

        // Invalid letter
        pulse(0, 5'd27);
        check("err_pulse", 32'({dd[0], busy[0], done[0], err[0]}), 32'b0001);
        cyc(1);
        check("err_clear", 32'({dd[0], busy[0], done[0], err[0]}), 32'b0000);

        // S with a Start for O while busy
        pulse(0, 5'd18);
        w20 = '0;
        for (int j = 0; j < 20; j++) begin
            w20 = {w20[18:0], dd[0]};
            if (j == 2) begin start[0] = 1'b1; ltr[0] = 5'd14; end
            else start[0] = 1'b0;
            cyc(1);
        end
        check("s_bits", 32'(w20), 32'h000F0F0F);
        check("s_done", 32'({busy[0], done[0]}), 32'b01);
        cyc(2);

        // Reset in the middle of O, then a clean A
        pulse(0, 5'd14);
        cyc(9);
        rst[0] = 1'b1;
        cyc(1);
        check("rst_mid", 32'({dd[0], busy[0], done[0], err[0]}), 32'd0);
        rst[0] = 1'b0;
        dc = 0;
        for (int j = 0; j < 60; j++) begin
            dc += int'(done[0]); cyc(1);
        end
        check("rst_no_done", dc, 0);
        pulse(0, 5'd0);
        w20 = '0;
        for (int j = 0; j < 20; j++) begin
            w20 = {w20[18:0], dd[0]}; cyc(1);
        end
        check("a2_bits", 32'(w20), 32'h000F0FFF);
        check("a2_done", 32'(done[0]), 32'd1);

        // Random traffic, checked by the per-cycle model
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < 3; i++) begin
                start[i] = ($urandom_range(0, 5) == 0);
                ltr[i]   = 5'($urandom_range(0, 31));
                if ($urandom_range(0, 39) == 0) rep[i] = ~rep[i];
                rst[i]   = ($urandom_range(0, 499) == 0);
            end
            cyc(1);
        end
        start = 3'b000; rep = 3'b000; rst = 3'b000;
        cyc(150);
        check("final_idle", 32'({dd, busy, done, err}), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
